// File: rtl/hms_clock_core.sv
// Hours/minutes/seconds timekeeping core with button-driven set mode.
// Define HOUR12_EN for 12-hour operation with a PM flag; default build is 24-hour.
module hms_clock_core #(
    parameter int unsigned P_SEC_WRAP  = 60,
    parameter int unsigned P_MIN_WRAP  = 60,
    parameter int unsigned P_HOUR_WRAP = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_mode,
    input  logic       i_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [1:0] o_mode,
    output logic [5:0] o_six_dp,
    output logic       o_pm
);

    typedef enum logic [1:0] {
        StClock   = 2'd0,
        StSetSec  = 2'd1,
        StSetMin  = 2'd2,
        StSetHour = 2'd3
    } mode_e;

    localparam logic [5:0] SecMax = 6'(P_SEC_WRAP - 1);
    localparam logic [5:0] MinMax = 6'(P_MIN_WRAP - 1);

`ifdef HOUR12_EN
    localparam logic [4:0] HourRst = 5'd12;
`else
    localparam logic [4:0] HourRst = 5'd0;
    localparam logic [4:0] HourMax = 5'(P_HOUR_WRAP - 1);
`endif

    mode_e      mode_q, mode_d;
    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] dp_q, dp_d;
    logic [5:0] sec_inc, min_inc;
    logic [4:0] hour_inc;
    logic       sec_carry, min_carry;
    logic       pm_q, pm_d, pm_toggle;

    // Increment values; anything at or past the limit (incl. unreachable codes) lands on 0.
    always_comb begin
        sec_inc   = (sec_q >= SecMax) ? 6'd0 : sec_q + 6'd1;
        min_inc   = (min_q >= MinMax) ? 6'd0 : min_q + 6'd1;
        sec_carry = (sec_q == SecMax);
        min_carry = (min_q == MinMax);
        pm_toggle = 1'b0;
`ifdef HOUR12_EN
        // 11 -> 12 flips AM/PM; 12 -> 1 does not. Out-of-range hours recover to 12.
        if (hour_q == 5'd11) begin
            hour_inc  = 5'd12;
            pm_toggle = 1'b1;
        end else if (hour_q == 5'd12) begin
            hour_inc = 5'd1;
        end else if (hour_q == 5'd0 || hour_q > 5'd12) begin
            hour_inc = 5'd12;
        end else begin
            hour_inc = hour_q + 5'd1;
        end
`else
        hour_inc = (hour_q >= HourMax) ? 5'd0 : hour_q + 5'd1;
`endif
    end

    always_comb begin
        mode_d = mode_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        pm_d   = pm_q;
        dp_d   = 6'b000000;

        if (i_mode) begin
            unique case (mode_q)
                StClock:   mode_d = StSetSec;
                StSetSec:  mode_d = StSetMin;
                StSetMin:  mode_d = StSetHour;
                StSetHour: mode_d = StClock;
                default:   mode_d = StClock;
            endcase
        end

        // A mode pulse discards a coincident inc; a tick only counts while in CLOCK.
        unique case (mode_q)
            StClock: begin
                if (i_tick) begin
                    sec_d = sec_inc;
                    if (sec_carry) begin
                        min_d = min_inc;
                        if (min_carry) begin
                            hour_d = hour_inc;
                            pm_d   = pm_q ^ pm_toggle;
                        end
                    end
                end
            end
            StSetSec:  if (i_inc && !i_mode) sec_d = sec_inc;
            StSetMin:  if (i_inc && !i_mode) min_d = min_inc;
            StSetHour: begin
                if (i_inc && !i_mode) begin
                    hour_d = hour_inc;
                    pm_d   = pm_q ^ pm_toggle;
                end
            end
            default: ;
        endcase

        unique case (mode_d)
            StSetSec:  dp_d = 6'b000011;
            StSetMin:  dp_d = 6'b001100;
            StSetHour: dp_d = 6'b110000;
            default:   dp_d = 6'b000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= StClock;
            sec_q  <= 6'd0;
            min_q  <= 6'd0;
            hour_q <= HourRst;
            pm_q   <= 1'b0;
            dp_q   <= 6'b000000;
        end else begin
            mode_q <= mode_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            pm_q   <= pm_d;
            dp_q   <= dp_d;
        end
    end

    assign o_sec    = sec_q;
    assign o_min    = min_q;
    assign o_hour   = hour_q;
    assign o_mode   = mode_q;
    assign o_six_dp = dp_q;
`ifdef HOUR12_EN
    assign o_pm = pm_q;
`else
    assign o_pm = 1'b0;
`endif

endmodule

// File: tb/tb_hms_clock_core.sv
// Scoreboard bench for hms_clock_core: directed pulses push expected snapshots, a
// negedge monitor pops and compares them. Honours HOUR12_EN.
module tb_hms_clock_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_tick, i_mode, i_inc;
    logic [5:0] o_sec, o_min, o_six_dp;
    logic [4:0] o_hour;
    logic [1:0] o_mode;
    logic       o_pm;

    hms_clock_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_tick   (i_tick),
        .i_mode   (i_mode),
        .i_inc    (i_inc),
        .o_sec    (o_sec),
        .o_min    (o_min),
        .o_hour   (o_hour),
        .o_mode   (o_mode),
        .o_six_dp (o_six_dp),
        .o_pm     (o_pm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic [1:0] mode;
        logic [5:0] dp;
        logic       pm;
    } exp_t;

    exp_t sb_q[$];
    logic chk = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam logic [5:0] Dp0 = 6'b000000;
    localparam logic [5:0] DpS = 6'b000011;
    localparam logic [5:0] DpM = 6'b001100;
    localparam logic [5:0] DpH = 6'b110000;
`ifdef HOUR12_EN
    localparam logic [4:0] RstHour = 5'd12;
`else
    localparam logic [4:0] RstHour = 5'd0;
`endif

    // Monitor: compares the DUT state against the oldest queued expectation.
    always @(negedge clk) begin
        if (chk) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: output presented but no expectation queued");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                if ({o_sec, o_min, o_hour, o_mode, o_six_dp, o_pm} !==
                    {e.sec, e.min, e.hour, e.mode, e.dp, e.pm}) begin
                    n_fail++;
                    $display("FAIL %s: got %0d:%0d:%0d mode=%0d dp=%b pm=%b, want %0d:%0d:%0d mode=%0d dp=%b pm=%b",
                             e.name, o_hour, o_min, o_sec, o_mode, o_six_dp, o_pm,
                             e.hour, e.min, e.sec, e.mode, e.dp, e.pm);
                end
            end
        end
    end

    task automatic step(input logic t, input logic m, input logic inc);
        i_tick = t;
        i_mode = m;
        i_inc  = inc;
        @(posedge clk);
        #1;
        i_tick = 1'b0;
        i_mode = 1'b0;
        i_inc  = 1'b0;
    endtask

    task automatic steps(input int n, input logic t, input logic m, input logic inc);
        repeat (n) step(t, m, inc);
    endtask

    task automatic expect_st(input string name, input logic [5:0] sec, input logic [5:0] min,
                             input logic [4:0] hour, input logic [1:0] mode,
                             input logic [5:0] dp, input logic pm);
        exp_t e;
        e.name = name;
        e.sec  = sec;
        e.min  = min;
        e.hour = hour;
        e.mode = mode;
        e.dp   = dp;
        e.pm   = pm;
        sb_q.push_back(e);
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        i_tick = 1'b0;
        i_mode = 1'b0;
        i_inc  = 1'b0;
        #2;
        expect_st("reset", 6'd0, 6'd0, RstHour, 2'd0, Dp0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef HOUR12_EN
        step(0, 1, 0);
        steps(59, 0, 0, 1);
        step(0, 1, 0);
        steps(59, 0, 0, 1);
        step(0, 1, 0);
        steps(11, 0, 0, 1);
        expect_st("preload_11", 6'd59, 6'd59, 5'd11, 2'd3, DpH, 1'b0);
        step(0, 1, 0);
        step(1, 0, 0);
        expect_st("to_12_pm", 6'd0, 6'd0, 5'd12, 2'd0, Dp0, 1'b1);
        step(0, 1, 0);
        steps(59, 0, 0, 1);
        step(0, 1, 0);
        steps(59, 0, 0, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        expect_st("preload_1259", 6'd59, 6'd59, 5'd12, 2'd0, Dp0, 1'b1);
        step(1, 0, 0);
        expect_st("to_1_no_toggle", 6'd0, 6'd0, 5'd1, 2'd0, Dp0, 1'b1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        steps(10, 0, 0, 1);
        expect_st("set_hour_11", 6'd0, 6'd0, 5'd11, 2'd3, DpH, 1'b1);
        step(0, 0, 1);
        expect_st("set_hour_12_toggle", 6'd0, 6'd0, 5'd12, 2'd3, DpH, 1'b0);
        step(0, 0, 1);
        expect_st("set_hour_1", 6'd0, 6'd0, 5'd1, 2'd3, DpH, 1'b0);
`else
        steps(61, 1, 0, 0);
        expect_st("tick61", 6'd1, 6'd1, 5'd0, 2'd0, Dp0, 1'b0);
        step(0, 0, 1);
        expect_st("inc_in_clock", 6'd1, 6'd1, 5'd0, 2'd0, Dp0, 1'b0);
        step(0, 1, 0);
        expect_st("enter_set_sec", 6'd1, 6'd1, 5'd0, 2'd1, DpS, 1'b0);
        steps(65, 0, 0, 1);
        expect_st("sec_inc65", 6'd6, 6'd1, 5'd0, 2'd1, DpS, 1'b0);
        steps(53, 0, 0, 1);
        expect_st("sec_59", 6'd59, 6'd1, 5'd0, 2'd1, DpS, 1'b0);
        step(0, 1, 1);
        expect_st("mode_beats_inc", 6'd59, 6'd1, 5'd0, 2'd2, DpM, 1'b0);
        steps(58, 0, 0, 1);
        expect_st("min_59", 6'd59, 6'd59, 5'd0, 2'd2, DpM, 1'b0);
        step(0, 1, 0);
        steps(10, 1, 0, 0);
        expect_st("frozen_ticks", 6'd59, 6'd59, 5'd0, 2'd3, DpH, 1'b0);
        steps(23, 0, 0, 1);
        expect_st("hour_23", 6'd59, 6'd59, 5'd23, 2'd3, DpH, 1'b0);
        step(1, 1, 0);
        expect_st("exit_tick_ignored", 6'd59, 6'd59, 5'd23, 2'd0, Dp0, 1'b0);
        step(1, 0, 0);
        expect_st("full_ripple", 6'd0, 6'd0, 5'd0, 2'd0, Dp0, 1'b0);
        step(1, 1, 0);
        expect_st("tick_with_mode", 6'd1, 6'd0, 5'd0, 2'd1, DpS, 1'b0);
        step(0, 1, 0);
        step(0, 1, 0);
        steps(25, 0, 0, 1);
        expect_st("hour_wrap_no_carry", 6'd1, 6'd0, 5'd1, 2'd3, DpH, 1'b0);
        step(0, 1, 0);
        expect_st("back_to_clock", 6'd1, 6'd0, 5'd1, 2'd0, Dp0, 1'b0);
        step(0, 1, 0);
        step(0, 1, 0);
        steps(7, 0, 0, 1);
        expect_st("min_7", 6'd1, 6'd7, 5'd1, 2'd2, DpM, 1'b0);
        #2;
        rst_n = 1'b0;
        expect_st("async_reset", 6'd0, 6'd0, 5'd0, 2'd0, Dp0, 1'b0);
        rst_n = 1'b1;
        step(1, 0, 0);
        expect_st("post_reset_tick", 6'd1, 6'd0, 5'd0, 2'd0, Dp0, 1'b0);
`endif

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hms_clock_core.md
Name: hms_clock_core

Overview:
- Hours/minutes/seconds timekeeping core with a button-driven set mode.
- Sits upstream of the six-digit LED multiplexer. It advances on a 1 Hz single-cycle tick produced by the NCO.
- Binary hour/min/sec feed the digit splitters and segment decoders.
- A per-digit decimal-point mask marks the field under edit and goes straight to the display's dp input.

Parameters:
- P_SEC_WRAP, 60, seconds count 0..P_SEC_WRAP-1.
- P_MIN_WRAP, 60, minutes count 0..P_MIN_WRAP-1.
- P_HOUR_WRAP, 24, hours count 0..P_HOUR_WRAP-1 (24-hour build only).

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- i_tick  input  1  1 Hz enable, one clk cycle high per second, synchronous to clk.
- i_mode  input  1  debounced single-cycle pulse; advances edit mode.
- i_inc  input  1  debounced single-cycle pulse; increments the selected field.
- o_sec  output  6  seconds, binary.
- o_min  output  6  minutes, binary.
- o_hour  output  5  hours, binary.
- o_mode  output  2  current mode: 0 CLOCK, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR.
- o_six_dp  output  6  dp mask for digits [5:0] (hour hi..sec lo), 1 = lit.
- o_pm  output  1  PM flag (12-hour build only, else constant 0).

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- All outputs are registered. A pulse sampled on clk edge N is visible after edge N; latency is 1 cycle.
- Reset values (async, immediate):
  - o_sec = 0, o_min = 0, o_hour = 0.
  - o_mode = CLOCK, o_six_dp = 6'b000000, o_pm = 0.
- Mode FSM, driven by i_mode only: CLOCK -> SET_SEC -> SET_MIN -> SET_HOUR -> CLOCK. No other transitions.
- CLOCK mode, on i_tick:
  - sec += 1.
  - If sec == P_SEC_WRAP-1: sec -> 0 and min += 1 in the same cycle.
  - If min also == P_MIN_WRAP-1: min -> 0 and hour += 1.
  - If hour == P_HOUR_WRAP-1: hour -> 0.
  - A full ripple 23:59:59 -> 00:00:00 completes in one cycle.
  - i_inc is ignored in CLOCK mode.
- SET modes:
  - i_tick is ignored; time is frozen and ticks are not accumulated.
  - i_inc increments only the selected field, wrapping at its limit with no carry into the next field.
- Priority within a cycle:
  - If i_mode and i_inc are both high, the mode change wins and i_inc is discarded.
  - If i_mode and i_tick are both high in CLOCK, the tick is applied and the mode advances in the same cycle.
  - If i_tick coincides with the i_mode that returns SET_HOUR -> CLOCK, the tick is ignored; counting resumes from the next tick.
- o_six_dp:
  - CLOCK: 000000.
  - SET_SEC: 000011.
  - SET_MIN: 001100.
  - SET_HOUR: 110000.
  - Updated in the same cycle as o_mode.
- Field values are always within range. Any out-of-range value (unreachable) is forced to 0 on the next tick or inc.
- Reset mid-edit returns to CLOCK at 00:00:00 immediately.

Optional Feature:
- Macro: HOUR12_EN.
- Defined (12-hour operation):
  - Hour ranges 1..12; reset hour = 12, o_pm = 0.
  - Hour 11 -> 12 toggles o_pm; hour 12 -> 1 does not toggle.
  - These rules apply to both carry increments and SET_HOUR increments.
  - P_HOUR_WRAP is unused.
- Undefined: 24-hour operation as above, with o_pm tied to 0.

Test Plan:
- Reset, then 61 ticks in CLOCK -> o_sec = 1, o_min = 1, o_hour = 0, o_six_dp = 000000.
- Preload 23:59:59 via set mode, return to CLOCK, 1 tick -> 00:00:00 one cycle after the tick.
- i_mode x1, i_inc x65 -> o_mode = 1, o_sec = 5, o_min unchanged (no carry), o_six_dp = 000011.
- i_mode x3, then 10 ticks -> o_mode = 3, then 0; time unchanged by ticks during edit.
- i_mode and i_inc high in the same cycle in SET_SEC -> o_mode = 2, o_sec unchanged.
- HOUR12_EN: reset -> hour = 12, o_pm = 0. Preload 11:59:59, 1 tick -> 12:00:00 with o_pm = 1. Drive to 12:59:59, 1 tick -> 01:00:00 with o_pm = 1.
- Assert rst_n low mid-SET_MIN -> all outputs at reset values without waiting for a clock edge.
